// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, memory select codes, word counts and scheduler states
package cnn_pkg;
    localparam int DATA_WIDTH = 20;
    localparam int ADDR_WIDTH = 12;
    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] L0_SEL = 3'b001;
    localparam logic [2:0] L1_SEL = 3'b011;
    localparam int CONV_WORDS = 4096;
    localparam int POOL_WORDS = 1024;
    typedef enum logic [2:0] {IDLE, C_START, C_RUN, P_START, P_RUN, FINISH} state_t;
endpackage

// File: rtl/layer_sched_if.sv
// layer_sched_if: host handshake, engine control/request and shared result-memory port
interface layer_sched_if;
    import cnn_pkg::*;
    logic ready, busy, err;
    logic conv_start, conv_done, conv_wreq, conv_gnt;
    logic [ADDR_WIDTH-1:0] conv_waddr;
    logic [DATA_WIDTH-1:0] conv_wdata;
    logic pool_start, pool_done, pool_rreq, pool_wreq, pool_gnt, pool_rvalid;
    logic [ADDR_WIDTH-1:0] pool_addr;
    logic [DATA_WIDTH-1:0] pool_wdata, pool_rdata;
    logic crd, cwr;
    logic [ADDR_WIDTH-1:0] caddr_rd, caddr_wr;
    logic [DATA_WIDTH-1:0] cdata_wr, cdata_rd;
    logic [2:0] csel;
    modport master (
        input  ready, conv_done, conv_wreq, conv_waddr, conv_wdata,
               pool_done, pool_rreq, pool_wreq, pool_addr, pool_wdata, cdata_rd,
        output busy, err, conv_start, conv_gnt, pool_start, pool_gnt, pool_rvalid,
               pool_rdata, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel
    );
    modport slave (
        output ready, conv_done, conv_wreq, conv_waddr, conv_wdata,
               pool_done, pool_rreq, pool_wreq, pool_addr, pool_wdata, cdata_rd,
        input  busy, err, conv_start, conv_gnt, pool_start, pool_gnt, pool_rvalid,
               pool_rdata, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/mem_port_mux.sv
// mem_port_mux: grants the shared result-memory port to the active engine and registers the port
module mem_port_mux
    import cnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  conv_act,
    input  logic                  pool_act,
    input  logic                  conv_wreq,
    input  logic [ADDR_WIDTH-1:0] conv_waddr,
    input  logic [DATA_WIDTH-1:0] conv_wdata,
    input  logic                  pool_rreq,
    input  logic                  pool_wreq,
    input  logic [ADDR_WIDTH-1:0] pool_addr,
    input  logic [DATA_WIDTH-1:0] pool_wdata,
    input  logic [DATA_WIDTH-1:0] cdata_rd,
    output logic                  conv_gnt,
    output logic                  pool_gnt,
    output logic                  pool_rvalid,
    output logic [DATA_WIDTH-1:0] pool_rdata,
    output logic                  crd,
    output logic                  cwr,
    output logic [ADDR_WIDTH-1:0] caddr_rd,
    output logic [ADDR_WIDTH-1:0] caddr_wr,
    output logic [DATA_WIDTH-1:0] cdata_wr,
    output logic [2:0]            csel
);
    logic pool_wgnt, pool_rgnt;
    // Grants: conv owns the port in its run phase; in the pool phase a write wins and a read waits
    always_comb begin
        conv_gnt = conv_act & conv_wreq;
        pool_wgnt = pool_act & pool_wreq;
        pool_rgnt = pool_act & pool_rreq & ~pool_wreq;
        pool_gnt = pool_wgnt | pool_rgnt;
    end
    // Output stage: strobes and select follow this cycle's grant, addresses and data hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            cwr <= 1'b0;
            crd <= 1'b0;
            csel <= NONE;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
        end else begin
            cwr <= conv_gnt | pool_wgnt;
            crd <= pool_rgnt;
            csel <= (conv_gnt | pool_rgnt) ? L0_SEL : pool_wgnt ? L1_SEL : NONE;
            caddr_wr <= conv_gnt ? conv_waddr : pool_wgnt ? pool_addr : caddr_wr;
            cdata_wr <= conv_gnt ? conv_wdata : pool_wgnt ? pool_wdata : cdata_wr;
            caddr_rd <= pool_rgnt ? pool_addr : caddr_rd;
        end
    end
    // Read return: memory data arrives during the strobe cycle and is presented one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            pool_rvalid <= 1'b0;
            pool_rdata <= '0;
        end else begin
            pool_rvalid <= crd;
            pool_rdata <= crd ? cdata_rd : pool_rdata;
        end
    end
endmodule

// File: rtl/layer_sched.sv
// layer_sched: conv-then-pool phase sequencer owning the shared result-memory port
// Optional write-count check enabled by defining LAYER_SCHED_WRCNT_CHECK_EN.
module layer_sched
    import cnn_pkg::*;
(
    input logic           clk,
    input logic           reset,
    layer_sched_if.master bus
);
    state_t state, state_nx;
    // State register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end
    // Next state and phase outputs
    always_comb begin
        state_nx = state;
        bus.busy = (state != IDLE) && (state != FINISH);
        bus.conv_start = (state == C_START);
        bus.pool_start = (state == P_START);
        case (state)
            IDLE:    state_nx = bus.ready ? C_START : IDLE;
            C_START: state_nx = C_RUN;
            C_RUN:   state_nx = bus.conv_done ? P_START : C_RUN;
            P_START: state_nx = P_RUN;
            P_RUN:   state_nx = bus.pool_done ? FINISH : P_RUN;
            default: state_nx = IDLE;
        endcase
    end
    mem_port_mux u_mux (
        .clk        (clk),
        .reset      (reset),
        .conv_act   (state == C_RUN),
        .pool_act   (state == P_RUN),
        .conv_wreq  (bus.conv_wreq),
        .conv_waddr (bus.conv_waddr),
        .conv_wdata (bus.conv_wdata),
        .pool_rreq  (bus.pool_rreq),
        .pool_wreq  (bus.pool_wreq),
        .pool_addr  (bus.pool_addr),
        .pool_wdata (bus.pool_wdata),
        .cdata_rd   (bus.cdata_rd),
        .conv_gnt   (bus.conv_gnt),
        .pool_gnt   (bus.pool_gnt),
        .pool_rvalid(bus.pool_rvalid),
        .pool_rdata (bus.pool_rdata),
        .crd        (bus.crd),
        .cwr        (bus.cwr),
        .caddr_rd   (bus.caddr_rd),
        .caddr_wr   (bus.caddr_wr),
        .cdata_wr   (bus.cdata_wr),
        .csel       (bus.csel)
    );
`ifdef LAYER_SCHED_WRCNT_CHECK_EN
    logic wr_gnt, err_q;
    logic [ADDR_WIDTH:0] wcnt, wcnt_nx;
    assign wr_gnt = bus.conv_gnt | (bus.pool_gnt & bus.pool_wreq);
    assign wcnt_nx = wcnt + {{ADDR_WIDTH{1'b0}}, wr_gnt};
    assign bus.err = err_q;
    // Count granted writes per phase (including one granted alongside done) and flag a wrong total
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt <= '0;
            err_q <= 1'b0;
        end else begin
            wcnt <= (state == C_START || state == P_START) ? '0 : wcnt_nx;
            err_q <= err_q
                | (state == C_RUN && bus.conv_done && wcnt_nx != (ADDR_WIDTH+1)'(CONV_WORDS))
                | (state == P_RUN && bus.pool_done && wcnt_nx != (ADDR_WIDTH+1)'(POOL_WORDS));
        end
    end
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: doc/layer_sched.md
# layer_sched

Top-level sequencer for the two-layer CNN accelerator. It accepts the host `ready`/`busy` handshake, starts the layer-0 convolution+ReLU engine and then the layer-1 max-pool engine, and multiplexes the single shared result-memory port (`crd`/`cwr`/`csel`/addresses/data) to whichever engine owns the current phase. It sits between the engines and the testbench memory interface.

## Interface
- `DATA_WIDTH`, 20, result word width
- `ADDR_WIDTH`, 12, memory address width
- `L0_SEL`, 3'b001, `csel` code for layer-0 memory
- `L1_SEL`, 3'b011, `csel` code for layer-1 memory
- `CONV_WORDS`, 4096, writes expected from conv engine
- `POOL_WORDS`, 1024, writes expected from pool engine
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `ready`  in  1  host start request
- `busy`  out  1  high from the cycle after `ready` is accepted until FINISH
- `conv_start` / `pool_start`  out  1  one-cycle start pulses to the engines
- `conv_done` / `pool_done`  in  1  engine completion pulses
- `conv_wreq`  in  1  conv write request; `conv_waddr` in ADDR_WIDTH; `conv_wdata` in DATA_WIDTH
- `conv_gnt`  out  1  combinational grant for conv request
- `pool_rreq`, `pool_wreq`  in  1  pool read/write requests; `pool_addr` in ADDR_WIDTH; `pool_wdata` in DATA_WIDTH
- `pool_gnt`  out  1  combinational grant for pool request
- `pool_rvalid`  out  1  read data valid; `pool_rdata` out DATA_WIDTH
- `crd`, `cwr`  out  1  memory read/write strobes (registered)
- `caddr_rd`, `caddr_wr`  out  ADDR_WIDTH  memory addresses (registered)
- `cdata_wr`  out  DATA_WIDTH  write data (registered); `cdata_rd` in DATA_WIDTH
- `csel`  out  3  memory select (registered)
- `err`  out  1  sticky write-count mismatch flag

## Operation
- FSM: IDLE → C_START → C_RUN → P_START → P_RUN → FINISH → IDLE.
- IDLE: `busy`=0; `ready`=1 → C_START. `ready` is ignored in all other states.
- C_START: `conv_start`=1 for one cycle → C_RUN.
- C_RUN: `conv_gnt`=`conv_wreq`; each grant → `cwr`=1, `csel`=L0_SEL, `caddr_wr`/`cdata_wr` from conv. `conv_done` → P_START.
- P_START: `pool_start` pulse → P_RUN.
- P_RUN: write has priority. `pool_wreq` → `cwr`=1, `csel`=L1_SEL. Else `pool_rreq` → `crd`=1, `csel`=L0_SEL, `caddr_rd`=`pool_addr`. `pool_gnt` is high only for the request taken; if both are asserted, the read is held off. `pool_done` → FINISH.
- FINISH: `busy`=0 for one cycle → IDLE.
- Requests or `done` pulses from the engine that is not active are ignored (gnt=0).
- `crd`/`cwr` deassert in any cycle with no grant; `csel` returns to 3'b000 and addresses/data hold their last values.
- `reset` mid-operation clears every output to 0 on the next edge. The FSM returns to IDLE, and no start pulse is issued.

## Timing
- Reset values: all outputs 0, `csel`=3'b000.
- `ready` sampled high at edge N → `busy`=1 and `conv_start`=1 in cycle N+1.
- Request granted in cycle N → strobe/address/data/`csel` driven in cycle N+1.
- Read granted in cycle N → `pool_rvalid`=1 in cycle N+2, with `pool_rdata` = `cdata_rd` sampled at the end of cycle N+1.
- Sustained throughput: one access per cycle.
- Done pulse at cycle N → next start pulse (or FINISH) in cycle N+1.

## Configuration
- `LAYER_SCHED_WRCNT_CHECK_EN` defined:
  - Per-phase write counters (ADDR_WIDTH+1 bits) count granted writes.
  - On `conv_done`/`pool_done`, a count ≠ CONV_WORDS/POOL_WORDS sets `err`. `err` stays set until reset.
  - Counters clear at their start pulse.
- Undefined: no counters; `err` tied 0.

## Structure
- Shared package `cnn_pkg`: DATA_WIDTH/ADDR_WIDTH, `csel` codes (L0_SEL, L1_SEL, NONE), FSM state enum, word counts.
- Sub-module `mem_port_mux`: grant logic plus the registered output stage and read-valid pipeline. The FSM stays in `layer_sched`.

## Test plan
- Reset then `ready`=1 for one cycle → `busy`=1 and `conv_start`=1 next cycle. `ready` held high afterwards causes no second start.
- Conv writes addr 0x000 data 0x01234 → next cycle `cwr`=1, `csel`=001, `caddr_wr`=0x000, `cdata_wr`=0x01234.
- In P_RUN, `pool_rreq` and `pool_wreq` asserted together (addr 0x005) → write taken with `csel`=011, read stalled (`pool_gnt` covers the write only). A lone read next cycle yields `pool_rvalid` two cycles later.
- `pool_wreq` asserted during C_RUN → `pool_gnt`=0, no `cwr`.
- Full run with 4096 + 1024 writes → `busy` falls after `pool_done`. With the macro, 4095 conv writes → `err`=1.
- `reset` asserted during P_RUN → all outputs 0 next cycle, FSM in IDLE, and a fresh `ready` restarts from C_START.
